// File: rtl/down_counter_timer_pkg.sv
// down_counter_timer_pkg: shared state encodings and default width for the down-counter timer
package down_counter_timer_pkg;
  localparam int WIDTH_DEFAULT = 8;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;
endpackage

// File: rtl/down_counter_timer_if.sv
// down_counter_timer_if: control and status bundle between a timer and its controller
interface down_counter_timer_if
  import down_counter_timer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) ();
  logic             enable;
  logic             load;
  logic [WIDTH-1:0] data;
  logic             start;
  logic             stop;
  logic             auto_reload;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             tc;
  modport master (
    output enable, load, data, start, stop, auto_reload,
    input  count, busy, done, tc
  );
  modport slave (
    input  enable, load, data, start, stop, auto_reload,
    output count, busy, done, tc
  );
endinterface

// File: rtl/down_counter_timer.sv
// down_counter_timer: loadable down-counter with one-shot/periodic expiry and terminal-count pulse
module down_counter_timer
  import down_counter_timer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input logic                 clk,
  input logic                 reset,
  down_counter_timer_if.slave bus
);
  state_t           state, state_n;
  logic [WIDTH-1:0] count_q, count_n;
  logic [WIDTH-1:0] reload_reg, reload_n;
  logic             tc_q, tc_n;
  logic             cnt_zero, cnt_one;
  assign cnt_zero = (count_q == '0);
  assign cnt_one  = (count_q == WIDTH'(1));
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      count_q    <= '0;
      reload_reg <= '0;
      tc_q       <= 1'b0;
    end else begin
      state      <= state_n;
      count_q    <= count_n;
      reload_reg <= reload_n;
      tc_q       <= tc_n;
    end
  end
  // Priority chain: load > stop > start > tick; stop swallows a simultaneous start.
  always_comb begin
    state_n  = state;
    count_n  = count_q;
    reload_n = reload_reg;
    tc_n     = 1'b0;
    if (bus.load) begin
      count_n  = bus.data;
      reload_n = bus.data;
      state_n  = IDLE;
    end else if (bus.stop) begin
      state_n = (state == RUN) ? IDLE : state;
    end else if (bus.start && state != RUN) begin
      if (!cnt_zero) begin
        state_n = RUN;
      end else if (reload_reg != '0) begin
        count_n = reload_reg;
        state_n = RUN;
      end
    end else if (state == RUN && bus.enable && !cnt_zero) begin
      if (cnt_one) begin
        tc_n    = 1'b1;
        count_n = bus.auto_reload ? reload_reg : '0;
        state_n = bus.auto_reload ? RUN : DONE;
      end else begin
        count_n = count_q - WIDTH'(1);
      end
    end
  end
  assign bus.count = count_q;
  assign bus.busy  = (state == RUN);
  assign bus.done  = (state == DONE);
  assign bus.tc    = tc_q;
endmodule

// File: tb/tb_down_counter_timer.sv
// tb_down_counter_timer: directed scoreboard bench for the down-counter timer
module tb_down_counter_timer;
  typedef struct {
    logic [7:0] c;
    logic       b;
    logic       d;
    logic       t;
    string      tag;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t q[$];
  exp_t mon_e;
  down_counter_timer_if #(.WIDTH(8)) bus ();
  down_counter_timer #(.WIDTH(8)) u_dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      n_chk++;
      if (bus.count !== mon_e.c || bus.busy !== mon_e.b || bus.done !== mon_e.d || bus.tc !== mon_e.t) begin
        n_fail++;
        $display("FAIL %s: got count=%0h busy=%b done=%b tc=%b, expected count=%0h busy=%b done=%b tc=%b",
                 mon_e.tag, bus.count, bus.busy, bus.done, bus.tc, mon_e.c, mon_e.b, mon_e.d, mon_e.t);
      end
    end
  end
  task automatic cyc(input logic en, ld, st, sp, ar, input logic [7:0] d,
                     input logic [7:0] ec, input logic eb, ed, et, input string tag);
    @(negedge clk);
    bus.enable      = en;
    bus.load        = ld;
    bus.start       = st;
    bus.stop        = sp;
    bus.auto_reload = ar;
    bus.data        = d;
    @(posedge clk);
    #1;
    q.push_back('{ec, eb, ed, et, tag});
  endtask
  initial begin
    bus.enable = 0; bus.load = 0; bus.start = 0; bus.stop = 0; bus.auto_reload = 0; bus.data = 0;
    repeat (2) @(posedge clk);
    #1 q.push_back('{8'h00, 1'b0, 1'b0, 1'b0, "reset_state"});
    @(negedge clk);
    reset = 1'b0;
    // reset mid-run with count=5
    cyc(0, 1, 0, 0, 0, 8'd5, 8'd5, 0, 0, 0, "t1_load5");
    cyc(0, 0, 1, 0, 0, 8'd0, 8'd5, 1, 0, 0, "t1_start");
    @(posedge clk);
    #1 reset = 1'b1;
    #1 q.push_back('{8'h00, 1'b0, 1'b0, 1'b0, "t1_async_reset"});
    @(negedge clk);
    reset = 1'b0;
    cyc(0, 0, 1, 0, 0, 8'd0, 8'd0, 0, 0, 0, "t1_start_ignored");
    // one-shot from 3
    cyc(0, 1, 0, 0, 0, 8'd3, 8'd3, 0, 0, 0, "t2_load3");
    cyc(0, 0, 1, 0, 0, 8'd0, 8'd3, 1, 0, 0, "t2_start");
    cyc(1, 0, 0, 0, 0, 8'd0, 8'd2, 1, 0, 0, "t2_tick1");
    cyc(1, 0, 0, 0, 0, 8'd0, 8'd1, 1, 0, 0, "t2_tick2");
    cyc(1, 0, 0, 0, 0, 8'd0, 8'd0, 0, 1, 1, "t2_expire");
    cyc(1, 0, 0, 0, 0, 8'd0, 8'd0, 0, 1, 0, "t2_done_hold1");
    cyc(1, 0, 0, 0, 0, 8'd0, 8'd0, 0, 1, 0, "t2_done_hold2");
    // restart from DONE reloads, then load beats start
    cyc(0, 0, 1, 0, 0, 8'd0, 8'd3, 1, 0, 0, "t5_restart_reload");
    cyc(0, 1, 1, 0, 0, 8'd9, 8'd9, 0, 0, 0, "t5_load_beats_start");
    // periodic reload of 4
    cyc(0, 1, 0, 0, 1, 8'd4, 8'd4, 0, 0, 0, "t3_load4");
    cyc(0, 0, 1, 0, 1, 8'd0, 8'd4, 1, 0, 0, "t3_start");
    for (int k = 1; k <= 12; k++)
      cyc(1, 0, 0, 0, 1, 8'd0, 8'(4 - (k % 4)), 1, 0, (k % 4) == 0, $sformatf("t3_tick%0d", k));
    cyc(0, 0, 0, 1, 1, 8'd0, 8'd4, 0, 0, 0, "t3_stop");
    // stop wins over start, resume from held count
    cyc(0, 1, 0, 0, 0, 8'd6, 8'd6, 0, 0, 0, "t4_load6");
    cyc(0, 0, 1, 0, 0, 8'd0, 8'd6, 1, 0, 0, "t4_start");
    cyc(1, 0, 0, 0, 0, 8'd0, 8'd5, 1, 0, 0, "t4_tick1");
    cyc(1, 0, 0, 0, 0, 8'd0, 8'd4, 1, 0, 0, "t4_tick2");
    cyc(1, 0, 1, 1, 0, 8'd0, 8'd4, 0, 0, 0, "t4_stop_and_start");
    cyc(1, 0, 0, 0, 0, 8'd0, 8'd4, 0, 0, 0, "t4_idle_enable");
    cyc(0, 0, 1, 0, 0, 8'd0, 8'd4, 1, 0, 0, "t4_resume");
    cyc(1, 0, 0, 0, 0, 8'd0, 8'd3, 1, 0, 0, "t4_tick3");
    cyc(0, 0, 0, 1, 0, 8'd0, 8'd3, 0, 0, 0, "t4_stop");
    // reload of 1 in periodic mode fires every tick
    cyc(0, 1, 0, 0, 1, 8'd1, 8'd1, 0, 0, 0, "r1_load1");
    cyc(0, 0, 1, 0, 1, 8'd0, 8'd1, 1, 0, 0, "r1_start");
    for (int k = 1; k <= 3; k++)
      cyc(1, 0, 0, 0, 1, 8'd0, 8'd1, 1, 0, 1, $sformatf("r1_tick%0d", k));
    cyc(0, 0, 0, 0, 1, 8'd0, 8'd1, 1, 0, 0, "r1_no_tick");
    // full-range one-shot, no wrap
    cyc(0, 1, 0, 0, 0, 8'hFF, 8'hFF, 0, 0, 0, "t6_loadFF");
    cyc(0, 0, 1, 0, 0, 8'd0, 8'hFF, 1, 0, 0, "t6_start");
    for (int k = 1; k <= 255; k++)
      cyc(1, 0, 0, 0, 0, 8'd0, 8'(255 - k), k < 255, k == 255, k == 255, $sformatf("t6_tick%0d", k));
    cyc(1, 0, 0, 0, 0, 8'd0, 8'd0, 0, 1, 0, "t6_no_wrap1");
    cyc(1, 0, 0, 0, 0, 8'd0, 8'd0, 0, 1, 0, "t6_no_wrap2");
    repeat (2) @(negedge clk);
    #1;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
